// File: rtl/param_connection_box.sv
// ----------------------------------------------------------------------------
// param_connection_box
//
// Connection box between a TRACK_W-wide routing track bus and NUM_PINS CLB
// input pins. Each pin's track select is loaded serially into a shadow
// register. It is copied to the active mux selects only by an explicit
// commit, so the fabric never sees a half-shifted configuration.
//
// Optional feature macro: CB_READBACK_EN
//   When defined, adds the cfg_readback input. A pulse on it copies the live
//   (active) configuration into the shadow register, so the configuration can
//   be shifted back out on scan_out.
//
// Ports:
//   scan_clk     in   clock for all scan and configuration state
//   rst          in   synchronous, active-high reset
//   scan_en      in   shift one bit per cycle into the shadow register
//   scan_in      in   serial configuration data
//   scan_out     out  shadow[0] (registered)
//   cfg_commit   in   pulse: copy shadow to active if exactly CFG_BITS shifted
//   cfg_readback in   (CB_READBACK_EN only) pulse: shadow <= active
//   trk_in       in   routing track values [TRACK_W]
//   pin_out      out  CLB pin drives [NUM_PINS], combinational from trk_in
//   cfg_valid    out  a configuration has been committed since reset
//   cfg_err      out  one-cycle pulse: commit rejected for wrong bit count
// ----------------------------------------------------------------------------
module param_connection_box #(
    parameter int TRACK_W  = 4,
    parameter int NUM_PINS = 5
) (
    input  logic                scan_clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic                scan_in,
    output logic                scan_out,
    input  logic                cfg_commit,
`ifdef CB_READBACK_EN
    input  logic                cfg_readback,
`endif
    input  logic [TRACK_W-1:0]  trk_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int SEL_W    = $clog2(TRACK_W + 1);
    localparam int CFG_BITS = NUM_PINS * SEL_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow_reg;
    logic [CFG_BITS-1:0] active_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                cfg_valid_reg;
    logic                cfg_err_reg;
    logic                readback_req;

`ifdef CB_READBACK_EN
    assign readback_req = cfg_readback;
`else
    assign readback_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scan / configuration state. Priority: rst > commit > readback > shift.
    // ------------------------------------------------------------------
    always_ff @(posedge scan_clk) begin
        if (rst) begin
            shadow_reg    <= '0;
            active_reg    <= '0;
            cnt_reg       <= '0;
            cfg_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            cfg_err_reg <= 1'b0;
            if (cfg_commit) begin
                // Shadow is left untouched; a re-commit needs a fresh load.
                cnt_reg <= '0;
                if (cnt_reg == CNT_FULL) begin
                    active_reg    <= shadow_reg;
                    cfg_valid_reg <= 1'b1;
                end else begin
                    cfg_err_reg <= 1'b1;
                end
            end else if (readback_req) begin
`ifdef CB_READBACK_EN
                shadow_reg <= active_reg;
`endif
                cnt_reg    <= '0;
            end else if (scan_en) begin
                shadow_reg <= {scan_in, shadow_reg[CFG_BITS-1:1]};
                // Saturating one past full lets an over-long load be detected.
                if (cnt_reg != CNT_SAT) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign scan_out  = shadow_reg[0];
    assign cfg_valid = cfg_valid_reg;
    assign cfg_err   = cfg_err_reg;

    // ------------------------------------------------------------------
    // Per-pin track mux. sel=k (1..TRACK_W) picks trk_in[k-1]; sel=0 and
    // any out-of-range code match no track, so the pin is driven low.
    // ------------------------------------------------------------------
    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            logic [SEL_W-1:0]   sel;
            logic [TRACK_W-1:0] hit;

            assign sel = active_reg[gi*SEL_W +: SEL_W];

            for (gk = 0; gk < TRACK_W; gk++) begin : g_trk
                assign hit[gk] = (sel == SEL_W'(gk + 1)) & trk_in[gk];
            end

            assign pin_out[gi] = |hit;
        end
    endgenerate

endmodule

// File: doc/param_connection_box.md
# param_connection_box

Parametrised connection box for the Cozy fabric routing channels. It connects NUM_PINS CLB input pins to a TRACK_W-wide routing track bus, and each pin's track choice is programmed over the serial scan chain. The configuration is double-buffered: bits shift into a shadow register and reach the active mux selects only on an explicit commit, so the fabric never sees partially shifted configuration. It generalises the fixed 4-track vertical/horizontal channel boxes to any track width and pin count, and adds load-length checking and a valid flag.

## Interface
Parameters:
- TRACK_W, 4, number of routing tracks on the channel (≥2)
- NUM_PINS, 5, number of CLB pins served by this box (≥1)
- SEL_W, $clog2(TRACK_W+1), derived (localparam), per-pin select field width
- CFG_BITS, NUM_PINS*SEL_W, derived (localparam), total scan chain length

Ports:
- scan_clk  in  1  single clock for scan and config state
- rst  in  1  reset, synchronous and active-high
- scan_en  in  1  shift enable, one bit per cycle
- scan_in  in  1  serial config data in
- scan_out  out  1  serial data out, = shadow[0]
- cfg_commit  in  1  pulse; copy shadow to active config
- trk_in  in  TRACK_W  routing track values
- pin_out  out  NUM_PINS  CLB pin drives
- cfg_valid  out  1  active config has been committed since reset
- cfg_err  out  1  one-cycle pulse; commit rejected (wrong bit count)

## Operation
- Shadow register shadow[CFG_BITS-1:0]. On a shift cycle: shadow <= {scan_in, shadow[CFG_BITS-1:1]}. The first bit shifted ends at bit 0.
- Pin p's select is active[p*SEL_W +: SEL_W]. sel=0 gives pin_out[p]=0 (disconnected). sel=k with 1≤k≤TRACK_W gives pin_out[p]=trk_in[k-1]. sel>TRACK_W gives 0.
- Shift counter cnt, width $clog2(CFG_BITS+2), increments on each shift and saturates at CFG_BITS+1.
- On cfg_commit:
  - If cnt==CFG_BITS: active <= shadow, cfg_valid <= 1, cnt <= 0.
  - Otherwise: active is unchanged, cfg_err pulses high for 1 cycle, cnt <= 0.
- Per-cycle priority, highest first: rst > cfg_commit > readback (if compiled in) > scan_en shift. A lower-priority action is dropped in a cycle where a higher one fires. The shadow is not shifted on a commit cycle.
- The shadow is retained after a commit, so an identical re-commit requires re-shifting CFG_BITS bits.
- Reset values: shadow=0, active=0 (all pins disconnected), cnt=0, cfg_valid=0, cfg_err=0. Therefore pin_out=0 and scan_out=0. A rst asserted mid-shift discards the partial load.

## Timing
- pin_out is combinational from trk_in and active: 0-cycle latency.
- Commit latency: active and pin_out reflect the new config in the cycle after the commit edge. cfg_valid rises on the same edge.
- cfg_err is registered: high exactly in the cycle after the rejected commit edge.
- scan_out is registered: shadow[0] after each shift edge.
- Back-to-back commits: the second sees cnt=0 and is rejected with cfg_err, unless CFG_BITS==0, which is illegal.

## Configuration
- Macro CB_READBACK_EN.
- Defined:
  - Adds input port cfg_readback (1 bit).
  - A pulse loads shadow <= active and sets cnt <= 0, so the live config can be shifted out on scan_out over CFG_BITS cycles.
  - Priority is below commit and above shift.
- Undefined: the port is absent and there is no path from active to shadow.

## Test plan
All scenarios use TRACK_W=4, NUM_PINS=5 (SEL_W=3, CFG_BITS=15).
- Reset: assert rst 2 cycles with trk_in=4'b1111 -> pin_out=5'b00000, cfg_valid=0, scan_out=0.
- Full load: shift 15 bits so that pin selects are {p4..p0}={4,3,2,1,0}, trk_in=4'b1010, then commit -> the next cycle gives pin_out=5'b10100 and cfg_valid=1.
- Short load: shift 14 bits, then commit -> cfg_err high for exactly 1 cycle, pin_out unchanged.
- Long load: shift 16 bits, then commit -> cfg_err high for exactly 1 cycle, pin_out unchanged.
- Out-of-range select: load sel=7 for pin 0 with trk_in=4'b1111 -> pin_out[0]=0.
- Commit and scan_en together: assert both with cnt=15 -> active updated from the pre-shift shadow, no shift. A following commit is rejected (cfg_err=1).
- CB_READBACK_EN: after the full load, pulse cfg_readback, then shift 15 cycles -> scan_out emits the committed bits LSB first, matching the loaded stream.
